// File: rtl/block_mover.sv
// rtl/block_mover.sv - single-order word mover between a device-section FIFO and an MCU DRAM page
module block_mover #(
  parameter int STALL_MAX = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ISSUE,
  input  logic [11:0] START,
  input  logic [5:0]  COUNT_REQ,
  input  logic [1:0]  SECTION,
  input  logic [1:0]  MODE,
  output logic [5:0]  COUNT_SENT,
  output logic        WORKING,
  output logic        IRQ,
  output logic        ABRUPT_STOP,
  output logic        FRDRAM_DEVERR,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [11:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  output logic [1:0]  DEV_SECTION,
  input  logic        DEV_EMPTY,
  input  logic [31:0] DEV_RDATA,
  input  logic        DEV_LAST,
  output logic        DEV_RD,
  input  logic        DEV_FULL,
  output logic        DEV_WR,
  output logic [31:0] DEV_WDATA,
  input  logic        DEV_ERR
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PUT} state_t;

  localparam logic [3:0] STALL_LAST = 4'(STALL_MAX - 1);

  state_t      state, state_d;
  logic [11:0] addr_q;
  logic [5:0]  req_q, sent_q, sent_inc;
  logic [1:0]  section_q;
  logic        d2m_q;
  logic [31:0] data_q;
  logic        last_q, irq_q, abrupt_q, deverr_q;
  logic [3:0]  stall_q;

  logic mode_ok, load, cap_dev, cap_mem, complete;
  logic stall_inc, stall_clr, set_abrupt, set_deverr;
  logic mem_req, mem_we, dev_rd, dev_wr;

  assign mode_ok  = (MODE == 2'b01) || (MODE == 2'b10);
  assign sent_inc = sent_q + 6'd1;

  always_comb begin
    state_d    = state;
    load       = 1'b0;
    cap_dev    = 1'b0;
    cap_mem    = 1'b0;
    complete   = 1'b0;
    stall_inc  = 1'b0;
    stall_clr  = 1'b0;
    set_abrupt = 1'b0;
    set_deverr = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    dev_rd     = 1'b0;
    dev_wr     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (ISSUE && mode_ok) begin
          load    = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // Abort conditions gate every handshake so nothing half-moves on the final edge
        if (!mode_ok) begin
          set_abrupt = 1'b1;
          state_d    = S_IDLE;
        end else if (!d2m_q && DEV_ERR) begin
          set_abrupt = 1'b1;
          set_deverr = 1'b1;
          state_d    = S_IDLE;
        end else if (sent_q == req_q) begin
          state_d = S_IDLE;
        end else if (d2m_q) begin
          if (!DEV_EMPTY) begin
            dev_rd    = 1'b1;
            cap_dev   = 1'b1;
            stall_clr = 1'b1;
            state_d   = S_PUT;
          end else begin
            stall_inc = 1'b1;
            if (stall_q == STALL_LAST) begin
              set_abrupt = 1'b1;
              state_d    = S_IDLE;
            end
          end
        end else begin
          mem_req = 1'b1;
          if (MEM_ACK) begin
            cap_mem = 1'b1;
            state_d = S_PUT;
          end
        end
      end
      S_PUT: begin
        if (!mode_ok) begin
          set_abrupt = 1'b1;
          state_d    = S_IDLE;
        end else if (!d2m_q && DEV_ERR) begin
          set_abrupt = 1'b1;
          set_deverr = 1'b1;
          state_d    = S_IDLE;
        end else if (d2m_q) begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          complete = MEM_ACK;
        end else if (!DEV_FULL) begin
          dev_wr    = 1'b1;
          stall_clr = 1'b1;
          complete  = 1'b1;
        end else begin
          stall_inc = 1'b1;
          if (stall_q == STALL_LAST) begin
            set_abrupt = 1'b1;
            state_d    = S_IDLE;
          end
        end
        if (complete) begin
          if (sent_inc == req_q) begin
            state_d = S_IDLE;
          end else if (last_q) begin
            set_abrupt = 1'b1;
            state_d    = S_IDLE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      req_q     <= '0;
      sent_q    <= '0;
      section_q <= '0;
      d2m_q     <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
      irq_q     <= 1'b0;
      abrupt_q  <= 1'b0;
      deverr_q  <= 1'b0;
      stall_q   <= '0;
    end else begin
      state <= state_d;
      if (load) begin
        addr_q    <= START;
        req_q     <= COUNT_REQ;
        section_q <= SECTION;
        d2m_q     <= (MODE == 2'b01);
        sent_q    <= '0;
        last_q    <= 1'b0;
        irq_q     <= 1'b0;
        abrupt_q  <= 1'b0;
        deverr_q  <= 1'b0;
        stall_q   <= '0;
      end
      if (cap_dev) begin
        data_q <= DEV_RDATA;
        last_q <= DEV_LAST;
      end
      if (cap_mem) data_q <= MEM_RDATA;
      if (stall_clr)      stall_q <= '0;
      else if (stall_inc) stall_q <= stall_q + 4'd1;
      if (complete) begin
        sent_q <= sent_inc;
        addr_q <= addr_q + 12'd1;
        if (d2m_q) irq_q <= last_q;
      end
      if (set_abrupt) abrupt_q <= 1'b1;
      if (set_deverr) deverr_q <= 1'b1;
    end
  end

  assign COUNT_SENT    = sent_q;
  assign WORKING       = (state != S_IDLE);
  assign IRQ           = irq_q;
  assign ABRUPT_STOP   = abrupt_q;
  assign FRDRAM_DEVERR = deverr_q;
  assign MEM_REQ       = mem_req;
  assign MEM_WE        = mem_we;
  assign MEM_ADDR      = addr_q;
  assign MEM_WDATA     = data_q;
  assign DEV_SECTION   = section_q;
  assign DEV_RD        = dev_rd;
  assign DEV_WR        = dev_wr;
  assign DEV_WDATA     = data_q;

endmodule

// File: tb/tb_block_mover.sv
// tb/tb_block_mover.sv - scoreboard bench for block_mover with FIFO/DRAM environment models
module tb_block_mover;

  localparam int K_MRD = 0;
  localparam int K_MWR = 1;
  localparam int K_DRD = 2;
  localparam int K_DWR = 3;

  typedef struct {int kind; logic [11:0] addr; logic [31:0] data;} bus_t;
  typedef struct {logic [5:0] cnt; logic irq; logic abr; logic derr; logic [1:0] sec; int wc;} st_t;
  typedef struct {logic last; logic [31:0] data;} fw_t;

  logic        CLK = 1'b0, RST = 1'b0, ISSUE = 1'b0;
  logic [11:0] START = '0;
  logic [5:0]  COUNT_REQ = '0;
  logic [1:0]  SECTION = '0, MODE = '0;
  logic [5:0]  COUNT_SENT;
  logic        WORKING, IRQ, ABRUPT_STOP, FRDRAM_DEVERR;
  logic        MEM_REQ, MEM_WE, MEM_ACK = 1'b0;
  logic [11:0] MEM_ADDR;
  logic [31:0] MEM_WDATA, MEM_RDATA = '0;
  logic [1:0]  DEV_SECTION;
  logic        DEV_EMPTY = 1'b1, DEV_LAST = 1'b0, DEV_RD, DEV_FULL = 1'b0, DEV_WR, DEV_ERR = 1'b0;
  logic [31:0] DEV_RDATA = '0, DEV_WDATA;

  block_mover dut (
    .CLK(CLK), .RST(RST), .ISSUE(ISSUE), .START(START), .COUNT_REQ(COUNT_REQ),
    .SECTION(SECTION), .MODE(MODE), .COUNT_SENT(COUNT_SENT), .WORKING(WORKING),
    .IRQ(IRQ), .ABRUPT_STOP(ABRUPT_STOP), .FRDRAM_DEVERR(FRDRAM_DEVERR),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA), .DEV_SECTION(DEV_SECTION),
    .DEV_EMPTY(DEV_EMPTY), .DEV_RDATA(DEV_RDATA), .DEV_LAST(DEV_LAST), .DEV_RD(DEV_RD),
    .DEV_FULL(DEV_FULL), .DEV_WR(DEV_WR), .DEV_WDATA(DEV_WDATA), .DEV_ERR(DEV_ERR)
  );

  initial forever #5 CLK = ~CLK;

  int checks = 0, errors = 0, done_cnt = 0;
  bit sb_on = 1'b1;
  bus_t bus_q[$];
  st_t  st_q[$];
  fw_t  fifo[$];
  logic [31:0] mem [4096];
  int ack_lo, ack_hi, emp_lo, emp_hi, ful_lo, ful_hi;
  int ack_left = 0, empty_wait = 0, full_wait = 0, sink_cnt = 0, err_word = -1;

  function automatic int rr(int lo, int hi);
    return (hi <= lo) ? lo : lo + int'($urandom_range(hi - lo, 0));
  endfunction

  task automatic drive_inputs();
    MEM_ACK   = (ack_left == 0);
    MEM_RDATA = mem[MEM_ADDR];
    DEV_EMPTY = (fifo.size() == 0) || (empty_wait > 0);
    DEV_RDATA = (fifo.size() != 0) ? fifo[0].data : 32'h0;
    DEV_LAST  = (fifo.size() != 0) ? fifo[0].last : 1'b0;
    DEV_FULL  = (full_wait > 0);
    DEV_ERR   = (err_word >= 0) && (sink_cnt == err_word);
  endtask

  // Environment: sample handshakes mid-cycle, apply them after the edge
  initial begin : env
    logic s_fire, s_we, s_req, s_rd, s_wr;
    logic [11:0] s_addr;
    logic [31:0] s_wdata;
    forever begin
      @(negedge CLK);
      s_fire = MEM_REQ && MEM_ACK; s_we = MEM_WE; s_req = MEM_REQ;
      s_addr = MEM_ADDR; s_wdata = MEM_WDATA; s_rd = DEV_RD; s_wr = DEV_WR;
      @(posedge CLK);
      #1;
      if (s_fire) begin
        if (s_we) mem[s_addr] = s_wdata;
        ack_left = rr(ack_lo, ack_hi);
      end else if (s_req && ack_left > 0) ack_left--;
      if (s_rd && fifo.size() > 0) begin
        void'(fifo.pop_front());
        empty_wait = rr(emp_lo, emp_hi);
      end else if (empty_wait > 0) empty_wait--;
      if (s_wr) begin
        sink_cnt++;
        full_wait = rr(ful_lo, ful_hi);
      end else if (full_wait > 0) full_wait--;
      drive_inputs();
    end
  end

  task automatic check_item(int kind, logic [11:0] addr, logic [31:0] data);
    bus_t e;
    checks++;
    if (bus_q.size() == 0) begin
      errors++;
      $display("FAIL bus_unexpected: got kind=%0d addr=%h data=%h, required no transaction", kind, addr, data);
    end else begin
      e = bus_q.pop_front();
      if (e.kind != kind || ((kind == K_MRD || kind == K_MWR) && e.addr != addr) ||
          (kind != K_MRD && e.data != data)) begin
        errors++;
        $display("FAIL bus_item: got kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h",
                 kind, addr, data, e.kind, e.addr, e.data);
      end
    end
  endtask

  st_t s;
  int wcyc = 0;
  bit prev_w = 1'b0;

  initial begin : monitor
    forever begin
      @(negedge CLK);
      if (sb_on) begin
        if (MEM_REQ && MEM_ACK) check_item(MEM_WE ? K_MWR : K_MRD, MEM_ADDR, MEM_WE ? MEM_WDATA : MEM_RDATA);
        if (DEV_RD) check_item(K_DRD, 12'h0, DEV_RDATA);
        if (DEV_WR) check_item(K_DWR, 12'h0, DEV_WDATA);
        if (!WORKING && (MEM_REQ || DEV_RD || DEV_WR)) begin
          checks++; errors++;
          $display("FAIL idle_bus: got req=%b rd=%b wr=%b, required all 0", MEM_REQ, DEV_RD, DEV_WR);
        end
      end
      if (WORKING) wcyc = prev_w ? wcyc + 1 : 1;
      if (sb_on && prev_w && !WORKING) begin
        checks++;
        if (st_q.size() == 0) begin
          errors++;
          $display("FAIL status_unexpected: got end of transfer, required none");
        end else begin
          s = st_q.pop_front();
          if ({COUNT_SENT, IRQ, ABRUPT_STOP, FRDRAM_DEVERR, DEV_SECTION} !== {s.cnt, s.irq, s.abr, s.derr, s.sec}) begin
            errors++;
            $display("FAIL status: got cnt=%0d irq=%b abrupt=%b deverr=%b sec=%0d, required cnt=%0d irq=%b abrupt=%b deverr=%b sec=%0d",
                     COUNT_SENT, IRQ, ABRUPT_STOP, FRDRAM_DEVERR, DEV_SECTION, s.cnt, s.irq, s.abr, s.derr, s.sec);
          end
          if (s.wc >= 0) begin
            checks++;
            if (wcyc != s.wc) begin
              errors++;
              $display("FAIL working_cycles: got %0d, required %0d", wcyc, s.wc);
            end
          end
        end
        checks++;
        if (bus_q.size() != 0) begin
          errors++;
          $display("FAIL bus_missing: got %0d transactions short, required 0", bus_q.size());
        end
        bus_q.delete();
        done_cnt++;
      end
      prev_w = WORKING;
    end
  end

  task automatic setup_env(int alo, int ahi, int elo, int ehi, int flo, int fhi);
    @(negedge CLK);
    #1;
    fifo.delete();
    ack_lo = alo; ack_hi = ahi; emp_lo = elo; emp_hi = ehi; ful_lo = flo; ful_hi = fhi;
    ack_left = rr(alo, ahi); empty_wait = 0; full_wait = 0; sink_cnt = 0; err_word = -1;
    drive_inputs();
  endtask

  task automatic fill_fifo(int n, int last_idx);
    for (int i = 0; i < n; i++) fifo.push_back('{(i == last_idx), $urandom});
    drive_inputs();
  endtask

  // Device->DRAM reference: words flow until the count is met, DEV_LAST is moved, or the FIFO runs dry
  task automatic exp_d2m(logic [11:0] start, int cnt, logic [1:0] sec, int wc);
    int moved = 0;
    logic lastf = 1'b0;
    logic [11:0] a;
    for (int i = 0; i < cnt; i++) begin
      if (i >= fifo.size()) break;
      a = start + 12'(i);
      bus_q.push_back('{K_DRD, 12'h0, fifo[i].data});
      bus_q.push_back('{K_MWR, a, fifo[i].data});
      moved++;
      lastf = fifo[i].last;
      if (lastf) break;
    end
    st_q.push_back('{6'(moved), (moved > 0) ? lastf : 1'b0, (moved < cnt), 1'b0, sec, wc});
  endtask

  // DRAM->device reference: every word is read then pushed, truncated at the word DEV_ERR hits
  task automatic exp_m2d(logic [11:0] start, int cnt, int errw, logic [1:0] sec, int wc);
    int n;
    logic [11:0] a;
    n = (errw >= 0 && errw < cnt) ? errw : cnt;
    for (int i = 0; i < n; i++) begin
      a = start + 12'(i);
      bus_q.push_back('{K_MRD, a, 32'h0});
      bus_q.push_back('{K_DWR, 12'h0, mem[a]});
    end
    st_q.push_back('{6'(n), 1'b0, (n < cnt), (n < cnt), sec, wc});
  endtask

  task automatic do_issue(logic [1:0] mode, logic [11:0] start, logic [5:0] cnt, logic [1:0] sec);
    @(posedge CLK);
    #1;
    MODE = mode; START = start; COUNT_REQ = cnt; SECTION = sec; ISSUE = 1'b1;
    @(posedge CLK);
    #1;
    ISSUE = 1'b0;
  endtask

  task automatic wait_done(int n);
    int t = 0;
    while (done_cnt < n && t < 3000) begin
      @(negedge CLK);
      t++;
    end
    if (done_cnt < n) begin
      checks++; errors++;
      $display("FAIL timeout: got %0d finished transfers, required %0d", done_cnt, n);
    end
  endtask

  task automatic check_zero(string name);
    logic [127:0] v;
    v = {COUNT_SENT, WORKING, IRQ, ABRUPT_STOP, FRDRAM_DEVERR, MEM_REQ, MEM_WE, MEM_ADDR,
         MEM_WDATA, DEV_SECTION, DEV_RD, DEV_WR, DEV_WDATA};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s: got outputs=%h, required all 0", name, v);
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no end of run, required finish");
    $fatal(1);
  end

  initial begin : stim
    int nd;
    logic [11:0] st;
    logic [1:0]  sec;
    int cnt, nf, li;
    nd = 0;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    ack_lo = 0; ack_hi = 0; emp_lo = 0; emp_hi = 0; ful_lo = 0; ful_hi = 0;
    repeat (3) @(negedge CLK);
    check_zero("reset_state");
    #1 RST = 1'b1;

    setup_env(0, 0, 0, 0, 0, 0);
    fill_fifo(4, -1);
    exp_d2m(12'h010, 4, 2'd1, 8);
    do_issue(2'b01, 12'h010, 6'd4, 2'd1);
    nd++; wait_done(nd);

    setup_env(0, 0, 0, 0, 0, 0);
    fill_fifo(10, 2);
    exp_d2m(12'h080, 10, 2'd2, 6);
    do_issue(2'b01, 12'h080, 6'd10, 2'd2);
    nd++; wait_done(nd);

    setup_env(2, 2, 0, 0, 3, 3);
    exp_m2d(12'hFFE, 3, -1, 2'd3, -1);
    do_issue(2'b10, 12'hFFE, 6'd3, 2'd3);
    nd++; wait_done(nd);

    setup_env(0, 0, 0, 0, 0, 0);
    fill_fifo(1, -1);
    exp_d2m(12'h100, 3, 2'd0, 17);
    do_issue(2'b01, 12'h100, 6'd3, 2'd0);
    nd++; wait_done(nd);

    setup_env(0, 0, 0, 0, 0, 0);
    err_word = 1;
    drive_inputs();
    exp_m2d(12'h040, 4, 1, 2'd1, 3);
    do_issue(2'b10, 12'h040, 6'd4, 2'd1);
    nd++; wait_done(nd);

    setup_env(0, 0, 0, 0, 0, 0);
    fill_fifo(2, -1);
    exp_d2m(12'h300, 0, 2'd2, 1);
    do_issue(2'b01, 12'h300, 6'd0, 2'd2);
    nd++; wait_done(nd);

    setup_env(0, 0, 0, 0, 0, 0);
    fill_fifo(6, -1);
    exp_d2m(12'h200, 6, 2'd1, 12);
    do_issue(2'b01, 12'h200, 6'd6, 2'd1);
    repeat (2) @(posedge CLK);
    #1;
    START = 12'h555; COUNT_REQ = 6'd2; SECTION = 2'd3; ISSUE = 1'b1;
    @(posedge CLK);
    #1;
    ISSUE = 1'b0;
    nd++; wait_done(nd);

    // MODE drops at the start of the 6th working cycle: two words done, third popped but unwritten
    setup_env(0, 0, 0, 0, 0, 0);
    fill_fifo(10, -1);
    bus_q.push_back('{K_DRD, 12'h0, fifo[0].data});
    bus_q.push_back('{K_MWR, 12'h020, fifo[0].data});
    bus_q.push_back('{K_DRD, 12'h0, fifo[1].data});
    bus_q.push_back('{K_MWR, 12'h021, fifo[1].data});
    bus_q.push_back('{K_DRD, 12'h0, fifo[2].data});
    st_q.push_back('{6'd2, 1'b0, 1'b1, 1'b0, 2'd0, 6});
    do_issue(2'b01, 12'h020, 6'd10, 2'd0);
    repeat (5) @(posedge CLK);
    #1;
    MODE = 2'b00;
    nd++; wait_done(nd);

    setup_env(0, 0, 0, 0, 0, 0);
    sb_on = 1'b0;
    fill_fifo(20, -1);
    do_issue(2'b01, 12'h400, 6'd20, 2'd3);
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (WORKING !== 1'b1) begin
      errors++;
      $display("FAIL working_before_reset: got %b, required 1", WORKING);
    end
    #2 RST = 1'b0;
    #1 check_zero("async_reset");
    @(negedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    check_zero("after_reset_release");
    bus_q.delete(); st_q.delete();
    sb_on = 1'b1;

    for (int it = 0; it < 40; it++) begin
      setup_env(0, 2, 0, 3, 0, 3);
      st  = 12'($urandom);
      sec = 2'($urandom);
      cnt = (it == 7) ? 63 : int'($urandom_range(12, 0));
      if ($urandom_range(1, 0) == 1) begin
        nf = cnt + int'($urandom_range(3, 0));
        li = ($urandom_range(1, 0) == 1) ? int'($urandom_range(cnt + 2, 0)) : -1;
        fill_fifo(nf, li);
        exp_d2m(st, cnt, sec, -1);
        do_issue(2'b01, st, 6'(cnt), sec);
      end else begin
        exp_m2d(st, cnt, -1, sec, -1);
        do_issue(2'b10, st, 6'(cnt), sec);
      end
      nd++; wait_done(nd);
    end

    repeat (4) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/block_mover.md
# block_mover

Word mover that executes one transfer order from the hyperfabric soft controller. It copies up to 63 32-bit words between one of four device-section FIFOs and an MCU DRAM page, then reports the result through the BLCK_* status lines. It sits directly downstream of the controller: it consumes BLCK_START / BLCK_COUNT_REQ / BLCK_SECTION / BLCK_ISSUE / RST_MVBLCK and produces BLCK_COUNT_SENT / BLCK_WORKING / BLCK_IRQ / BLCK_ABRUPT_STOP / BLCK_FRDRAM_DEVERR.

## Interface
- STALL_MAX, 15: device-side wait cycles tolerated before abort (4-bit counter).
- CLK  in  1  sole clock, all state on rising edge.
- RST  in  1  reset, asynchronous, active-low.
- ISSUE  in  1  one-cycle start pulse.
- START  in  12  first DRAM column address.
- COUNT_REQ  in  6  words requested.
- SECTION  in  2  device section selected for this transfer.
- MODE  in  2  2'b01 = device→DRAM; 2'b10 = DRAM→device; 2'b00 or 2'b11 = hold idle / abort.
- COUNT_SENT  out  6  words completed.
- WORKING  out  1  transfer in progress.
- IRQ  out  1  last word moved carried DEV_LAST.
- ABRUPT_STOP  out  1  ended before COUNT_REQ words.
- FRDRAM_DEVERR  out  1  DEV_ERR seen during a DRAM→device transfer.
- MEM_REQ  out  1  word request to MCU.
- MEM_WE  out  1  1 = write, 0 = read.
- MEM_ADDR  out  12  column address.
- MEM_WDATA  out  32  write data.
- MEM_ACK  in  1  completes the request in the same cycle.
- MEM_RDATA  in  32  read data, valid with MEM_ACK.
- DEV_SECTION  out  2  latched SECTION.
- DEV_EMPTY  in  1  source FIFO empty.
- DEV_RDATA  in  32  head word, valid while !DEV_EMPTY; first-word-fall-through.
- DEV_LAST  in  1  head word is end-of-packet.
- DEV_RD  out  1  pop head.
- DEV_FULL  in  1  sink FIFO full.
- DEV_WR  out  1  push DEV_WDATA.
- DEV_WDATA  out  32  data to device.
- DEV_ERR  in  1  device error.

## Operation
- FSM states: IDLE, FETCH, PUT.
- **IDLE**
  - ISSUE with MODE ∈ {01, 10}:
    - latch START into the address register, and COUNT_REQ, SECTION and MODE;
    - clear COUNT_SENT, IRQ, ABRUPT_STOP, FRDRAM_DEVERR and the stall counter;
    - WORKING←1, go to FETCH.
  - ISSUE with MODE = 00 or 11: ignored.
  - ISSUE while WORKING: ignored.
- **COUNT_REQ = 0**: FETCH completes immediately with no bus activity. WORKING is high for exactly one cycle and ABRUPT_STOP stays 0.
- **Device→DRAM**
  - FETCH: when !DEV_EMPTY, pulse DEV_RD, latch DEV_RDATA and DEV_LAST, go to PUT.
  - PUT: hold MEM_REQ=1, MEM_WE=1 with latched data until MEM_ACK.
- **DRAM→device**
  - FETCH: hold MEM_REQ=1, MEM_WE=0 until MEM_ACK; latch MEM_RDATA; go to PUT.
  - PUT: when !DEV_FULL, pulse DEV_WR.
- **Word completion** (edge of MEM_ACK in PUT, or of DEV_WR):
  - COUNT_SENT+1, address+1 modulo 4096 (wraps 0xFFF→0x000);
  - IRQ←latched DEV_LAST (device→DRAM only).
  - If COUNT_SENT+1 = COUNT_REQ: finish normally.
  - Else if DEV_LAST: finish with ABRUPT_STOP=1.
  - Else: back to FETCH.
- **Stall**: the counter increments on each cycle spent waiting on DEV_EMPTY or DEV_FULL, and clears on any device handshake. When it reaches STALL_MAX: finish with ABRUPT_STOP=1. MEM_ACK waits never abort.
- **DEV_ERR** in any DRAM→device cycle: FRDRAM_DEVERR←1 and ABRUPT_STOP←1, finish; the current word is not counted.
- **MODE leaves 01/10 mid-transfer**: finish next edge with ABRUPT_STOP=1; counts stay as they are.
- **Finish**: WORKING←0, state←IDLE, and all status registers hold their final values on the same edge. Status stays stable until the next accepted ISSUE.

## Timing
- Reset: all outputs 0, state IDLE.
- WORKING rises on the edge after the ISSUE cycle.
- With zero waits each word costs 2 cycles. COUNT_REQ = N gives WORKING high for 2N cycles.
- COUNT_SENT, IRQ, ABRUPT_STOP and FRDRAM_DEVERR are final in the first cycle WORKING is low.
- MEM_REQ, DEV_RD and DEV_WR are never asserted in IDLE.
- MEM_ADDR and MEM_WDATA are stable throughout MEM_REQ.
- Asynchronous reset mid-transfer: outputs drop to 0 immediately; no partial word is completed.

## Test plan
- **Device→DRAM, no waits**: MODE=01, START=0x010, COUNT_REQ=4, FIFO holds 4 words. Required: MEM writes to 0x010–0x013 in order; WORKING high 8 cycles; COUNT_SENT=4; IRQ=0; ABRUPT_STOP=0.
- **Early end, device→DRAM**: COUNT_REQ=10, third word has DEV_LAST. Required: COUNT_SENT=3, IRQ=1, ABRUPT_STOP=1.
- **DRAM→device with waits**: MODE=10, START=0xFFE, COUNT_REQ=3, MEM_ACK delayed 2 cycles per word, DEV_FULL pulsed 3 cycles. Required: addresses 0xFFE, 0xFFF, 0x000; COUNT_SENT=3; no abort.
- **Stall timeout**: DEV_EMPTY held high after 1 word. Required: ABRUPT_STOP=1 and COUNT_SENT=1 after 15 wait cycles; DEV_ERR asserted on word 2 of a DRAM→device run gives FRDRAM_DEVERR=1 and COUNT_SENT=1.
- **Control edge cases**: COUNT_REQ=0 gives WORKING high 1 cycle. A second ISSUE during WORKING is ignored. MODE→00 mid-run gives ABRUPT_STOP=1. RST low mid-run clears all outputs asynchronously.
